jtag_tap_controller: RTL and testbench
======================================

Name: jtag_tap_controller

Overview:
IEEE 1149.1-style TAP controller that sequences the boundary-scan chain built from the team's boundary cells. It runs the 16-state TAP FSM from tms. It holds a 4-bit instruction register, a 1-bit bypass register and a 32-bit IDCODE register. It drives the chain's capture, shift, update and mode controls as single-clock enables and muxes tdo. It sits between the DPI JTAG driver and the boundary chain wrapper.

Parameters:
IR_WIDTH, 4, instruction register width (minimum 2)
IDCODE_VAL, 32'h1000_563D, value captured into the IDCODE register (bit0 must be 1)
INSTR_EXTEST, 4'b0000, EXTEST opcode
INSTR_SAMPLE, 4'b0001, SAMPLE/PRELOAD opcode
INSTR_IDCODE, 4'b0010, IDCODE opcode (BYPASS = all ones; any undefined opcode also selects bypass)

Ports:
clk  input  1  TCK-equivalent; all state changes on the rising edge
reset  input  1  asynchronous, active-high; forces Test-Logic-Reset
tms  input  1  test mode select, sampled on rising clk
tdi  input  1  test data in
tdo  output  1  test data out (combinational mux)
tdo_en  output  1  high in Shift-IR / Shift-DR only
bsr_tdo  input  1  serial out of the last boundary cell (its shiftOUT)
bsr_clk_en  output  1  clock enable for boundary shift flops (capture or shift of the boundary DR)
bsr_shift  output  1  boundary cell shiftDR select
bsr_update  output  1  one-cycle update strobe for boundary update flops
bsr_mode  output  1  boundary cell mode; 1 = drive parallelOUT from update flop
ir_out  output  IR_WIDTH  current instruction
tap_state  output  4  current FSM state encoding, for debug and checkers

Behaviour:
- State encoding is fixed:
  - TLR=0, RTI=1, SEL_DR=2, CAP_DR=3, SH_DR=4, EX1_DR=5, PA_DR=6, EX2_DR=7, UPD_DR=8
  - SEL_IR=9, CAP_IR=10, SH_IR=11, EX1_IR=12, PA_IR=13, EX2_IR=14, UPD_IR=15
- Transitions on rising clk use tms (next state for tms=0 / tms=1):
  - TLR: RTI / TLR
  - RTI: RTI / SEL_DR
  - SEL_DR: CAP_DR / SEL_IR
  - CAP_DR: SH_DR / EX1_DR
  - SH_DR: SH_DR / EX1_DR
  - EX1_DR: PA_DR / UPD_DR
  - PA_DR: PA_DR / EX2_DR
  - EX2_DR: SH_DR / UPD_DR
  - UPD_DR: RTI / SEL_DR
  - The IR branch is identical with IR states; SEL_IR with tms=1 goes to TLR.
- Five consecutive tms=1 cycles reach TLR from any state.
- Reset (asynchronous) forces the following, whatever the state, including mid-shift:
  - state=TLR, ir=INSTR_IDCODE, ir_sr=0, bypass=0, idcode_sr=0
  - all outputs low except ir_out=INSTR_IDCODE and tap_state=0
- While in TLR, ir is reloaded to INSTR_IDCODE every cycle.
- IR path:
  - CAP_IR: ir_sr <= {zeros, 2'b01}
  - SH_IR: ir_sr <= {tdi, ir_sr[IR_WIDTH-1:1]}
  - UPD_IR: ir <= ir_sr; the new instruction is effective the cycle after UPD_IR
- DR select is decoded from ir: EXTEST/SAMPLE → boundary, IDCODE → idcode, everything else → bypass.
- Bypass register: CAP_DR loads 0; SH_DR loads tdi.
- IDCODE register: CAP_DR loads IDCODE_VAL; SH_DR loads {tdi, idcode_sr[31:1]}.
- Outputs are decoded combinationally from the current state and ir:
  - bsr_clk_en = (CAP_DR or SH_DR) and DR select = boundary
  - bsr_shift = SH_DR and DR select = boundary
  - bsr_update = UPD_DR and DR select = boundary; exactly one cycle per UPD_DR visit
  - bsr_mode = (ir == INSTR_EXTEST); changes only after UPD_IR or on reset/TLR
- tdo:
  - SH_IR: ir_sr[0]
  - SH_DR: bsr_tdo, idcode_sr[0] or bypass, per DR select
  - otherwise 0
- tdo_en = SH_IR or SH_DR.
- Pause states hold every shift register unchanged.
- A SEL_DR → SEL_IR → TLR escape leaves ir unchanged until TLR reloads it.

Test Plan:
- Assert reset mid SH_DR → tap_state=0, ir_out=4'b0010, bsr_mode=0 and all strobes 0 immediately, without waiting for a clk edge.
- From RTI, tms = 1,1,1,1,1 → tap_state=0 after the 5th edge, from every starting state (16 sweeps).
- After reset, scan DR with tms 1,0,0, then 32 shifts with tdi=0 → tdo sequence LSB-first = 32'h1000_563D.
- Load IR with 4'b0000:
  - CAP_IR shifts out 2'b01 in the first two tdo bits
  - bsr_mode rises the cycle after UPD_IR
  - a following DR scan of N bits asserts bsr_clk_en for N+1 cycles, bsr_shift for N cycles and bsr_update for exactly 1 cycle
- Load IR 4'b1111 (BYPASS), shift tdi pattern 1,0,1,1 → tdo = 0,1,0,1 (one-cycle delay, leading 0); bsr_* stay 0.
- Load IR 4'b0001 with pause mid-shift (PA_IR for 3 cycles, then resume via EX2_IR) → ir_sr unchanged during pause, final ir_out=4'b0001, bsr_mode=0.

Source files
------------

// File: rtl/jtag_tap_controller.sv
// -----------------------------------------------------------------------------
// jtag_tap_controller
//
// IEEE 1149.1-style Test Access Port controller. It sits between the JTAG
// driver and the boundary-scan chain wrapper. It does four jobs:
//   - runs the 16-state TAP state machine from tms
//   - keeps the instruction register and its shift stage
//   - keeps the 1-bit bypass register and the 32-bit IDCODE register
//   - decodes the boundary-chain enables and steers tdo
//
// Ports
//   clk         TCK-equivalent; every state change happens on its rising edge
//   reset       asynchronous, active-high; forces Test-Logic-Reset
//   tms         test mode select, sampled on the rising edge of clk
//   tdi         serial test data in
//   tdo         serial test data out (combinational mux)
//   tdo_en      high only in Shift-IR and Shift-DR
//   bsr_tdo     serial output of the last boundary cell in the chain
//   bsr_clk_en  clock enable for the boundary shift flops (capture or shift)
//   bsr_shift   boundary cell shift select (high in Shift-DR)
//   bsr_update  single-cycle strobe for the boundary update flops
//   bsr_mode    boundary cell mode; 1 = cells drive parallel out from update flop
//   ir_out      current (effective) instruction
//   tap_state   current TAP state encoding, for debug and checkers
// -----------------------------------------------------------------------------
module jtag_tap_controller #(
  parameter int unsigned         IR_WIDTH     = 4,
  parameter logic [31:0]         IDCODE_VAL   = 32'h1000_563D,
  parameter logic [IR_WIDTH-1:0] INSTR_EXTEST = IR_WIDTH'(4'b0000),
  parameter logic [IR_WIDTH-1:0] INSTR_SAMPLE = IR_WIDTH'(4'b0001),
  parameter logic [IR_WIDTH-1:0] INSTR_IDCODE = IR_WIDTH'(4'b0010)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tms,
  input  logic                tdi,
  output logic                tdo,
  output logic                tdo_en,
  input  logic                bsr_tdo,
  output logic                bsr_clk_en,
  output logic                bsr_shift,
  output logic                bsr_update,
  output logic                bsr_mode,
  output logic [IR_WIDTH-1:0] ir_out,
  output logic [3:0]          tap_state
);

  // The encoding is visible on tap_state, so every value is pinned explicitly.
  typedef enum logic [3:0] {
    TLR    = 4'd0,
    RTI    = 4'd1,
    SEL_DR = 4'd2,
    CAP_DR = 4'd3,
    SH_DR  = 4'd4,
    EX1_DR = 4'd5,
    PA_DR  = 4'd6,
    EX2_DR = 4'd7,
    UPD_DR = 4'd8,
    SEL_IR = 4'd9,
    CAP_IR = 4'd10,
    SH_IR  = 4'd11,
    EX1_IR = 4'd12,
    PA_IR  = 4'd13,
    EX2_IR = 4'd14,
    UPD_IR = 4'd15
  } tapStateT;

  tapStateT            state;
  logic [IR_WIDTH-1:0] irReg;
  logic [IR_WIDTH-1:0] irShift;
  logic                bypassReg;
  logic [31:0]         idcodeShift;

  // Data-register select, decoded from the effective instruction only.
  // Any opcode that is not one of the three known opcodes falls back to bypass.
  logic selBoundary;
  logic selIdcode;

  // ---------------------------------------------------------------------------
  // TAP state machine
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= TLR;
    end else begin
      case (state)
        TLR:    state <= tms ? TLR    : RTI;
        RTI:    state <= tms ? SEL_DR : RTI;
        SEL_DR: state <= tms ? SEL_IR : CAP_DR;
        CAP_DR: state <= tms ? EX1_DR : SH_DR;
        SH_DR:  state <= tms ? EX1_DR : SH_DR;
        EX1_DR: state <= tms ? UPD_DR : PA_DR;
        PA_DR:  state <= tms ? EX2_DR : PA_DR;
        EX2_DR: state <= tms ? UPD_DR : SH_DR;
        UPD_DR: state <= tms ? SEL_DR : RTI;
        // Escaping from SEL_IR returns to TLR; the IR itself is left alone here
        // and only gets reloaded once TLR is actually occupied.
        SEL_IR: state <= tms ? TLR    : CAP_IR;
        CAP_IR: state <= tms ? EX1_IR : SH_IR;
        SH_IR:  state <= tms ? EX1_IR : SH_IR;
        EX1_IR: state <= tms ? UPD_IR : PA_IR;
        PA_IR:  state <= tms ? EX2_IR : PA_IR;
        EX2_IR: state <= tms ? UPD_IR : SH_IR;
        UPD_IR: state <= tms ? SEL_DR : RTI;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Instruction register and its shift stage
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irReg   <= INSTR_IDCODE;
      irShift <= '0;
    end else begin
      case (state)
        // Holding TLR keeps the device in IDCODE, so a fresh scan after any
        // reset path always reads the identification code.
        TLR:     irReg   <= INSTR_IDCODE;
        // The fixed 01 in the low bits lets the host confirm IR length and
        // chain integrity on every IR scan.
        CAP_IR:  irShift <= IR_WIDTH'(2'b01);
        SH_IR:   irShift <= {tdi, irShift[IR_WIDTH-1:1]};
        // The new instruction becomes effective the cycle after UPD_IR.
        UPD_IR:  irReg   <= irShift;
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Bypass and IDCODE data registers. Both capture and shift on every DR scan.
  // Only the selected register reaches tdo, so loading the other one is harmless.
  // Exit and pause states fall through and hold their contents.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bypassReg   <= 1'b0;
      idcodeShift <= '0;
    end else if (state == CAP_DR) begin
      bypassReg   <= 1'b0;
      idcodeShift <= IDCODE_VAL;
    end else if (state == SH_DR) begin
      bypassReg   <= tdi;
      idcodeShift <= {tdi, idcodeShift[31:1]};
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode. Every output is a function of registered state and IR only,
  // so each strobe lasts exactly as long as its state, and UPD_DR gives one cycle.
  // ---------------------------------------------------------------------------
  assign selBoundary = (irReg == INSTR_EXTEST) || (irReg == INSTR_SAMPLE);
  assign selIdcode   = !selBoundary && (irReg == INSTR_IDCODE);

  assign bsr_clk_en = ((state == CAP_DR) || (state == SH_DR)) && selBoundary;
  assign bsr_shift  = (state == SH_DR) && selBoundary;
  assign bsr_update = (state == UPD_DR) && selBoundary;
  // Mode follows the effective instruction, so it moves only after UPD_IR or TLR.
  assign bsr_mode   = (irReg == INSTR_EXTEST);

  assign tdo_en    = (state == SH_IR) || (state == SH_DR);
  assign ir_out    = irReg;
  assign tap_state = state;

  always_comb begin
    tdo = 1'b0;
    if (state == SH_IR) begin
      tdo = irShift[0];
    end else if (state == SH_DR) begin
      if (selBoundary) begin
        tdo = bsr_tdo;
      end else if (selIdcode) begin
        tdo = idcodeShift[0];
      end else begin
        tdo = bypassReg;
      end
    end
  end

endmodule

// File: tb/tb_jtag_tap_controller.sv
// -----------------------------------------------------------------------------
// tb_jtag_tap_controller
//
// Drives directed TAP scans and then a randomized tms/tdi stream, including
// occasional asynchronous resets. Every cycle the DUT outputs are compared
// against a transaction-level reference model held in this bench. The model
// uses a next-state lookup table and integer arithmetic for the registers.
// -----------------------------------------------------------------------------
module tb_jtag_tap_controller;

  logic       clk;
  logic       reset;
  logic       tms;
  logic       tdi;
  logic       tdo;
  logic       tdo_en;
  logic       bsr_tdo;
  logic       bsr_clk_en;
  logic       bsr_shift;
  logic       bsr_update;
  logic       bsr_mode;
  logic [3:0] ir_out;
  logic [3:0] tap_state;

  jtag_tap_controller dut (
    .clk       (clk),
    .reset     (reset),
    .tms       (tms),
    .tdi       (tdi),
    .tdo       (tdo),
    .tdo_en    (tdo_en),
    .bsr_tdo   (bsr_tdo),
    .bsr_clk_en(bsr_clk_en),
    .bsr_shift (bsr_shift),
    .bsr_update(bsr_update),
    .bsr_mode  (bsr_mode),
    .ir_out    (ir_out),
    .tap_state (tap_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Next-state tables indexed by state, one table per tms value.
  int nextOnTms0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
  int nextOnTms1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2,  0, 12, 12, 15, 14, 15, 2};

  localparam logic [31:0] IDCODE = 32'h1000_563D;

  int          nVec = 0;
  int          nErr = 0;

  // Reference model state.
  int          mState;
  logic [3:0]  mIr;
  logic [3:0]  mIrSr;
  logic        mBypass;
  logic [31:0] mIdc;

  // Strobe counters, active only while counting is set.
  logic        counting = 1'b0;
  int          cntClkEn, cntShift, cntUpdate;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nVec++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    mState  = 0;
    mIr     = 4'h2;
    mIrSr   = 4'h0;
    mBypass = 1'b0;
    mIdc    = 32'h0;
  endtask

  // Advance the model by one rising edge, using the pre-edge state.
  task automatic modelStep(input logic t, input logic d);
    int s;
    s = mState;
    if (s == 0)  mIr   = 4'h2;
    if (s == 10) mIrSr = 4'h1;
    if (s == 11) mIrSr = (mIrSr >> 1) | (4'(d) << 3);
    if (s == 15) mIr   = mIrSr;
    if (s == 3) begin
      mBypass = 1'b0;
      mIdc    = IDCODE;
    end
    if (s == 4) begin
      mBypass = d;
      mIdc    = (mIdc >> 1) | (32'(d) << 31);
    end
    mState = t ? nextOnTms1[s] : nextOnTms0[s];
  endtask

  task automatic compareAll(input string tag);
    logic bnd, idc, eTdo;
    bnd  = (mIr == 4'h0) || (mIr == 4'h1);
    idc  = (mIr == 4'h2);
    eTdo = 1'b0;
    if (mState == 11) eTdo = mIrSr[0];
    else if (mState == 4) eTdo = bnd ? bsr_tdo : (idc ? mIdc[0] : mBypass);
    checkVal({tag, ".state"},  32'(tap_state),  32'(mState));
    checkVal({tag, ".ir"},     32'(ir_out),     32'(mIr));
    checkVal({tag, ".tdo"},    32'(tdo),        32'(eTdo));
    checkVal({tag, ".tdoen"},  32'(tdo_en),     32'(mState == 4 || mState == 11));
    checkVal({tag, ".clken"},  32'(bsr_clk_en), 32'((mState == 3 || mState == 4) && bnd));
    checkVal({tag, ".shift"},  32'(bsr_shift),  32'(mState == 4 && bnd));
    checkVal({tag, ".update"}, 32'(bsr_update), 32'(mState == 8 && bnd));
    checkVal({tag, ".mode"},   32'(bsr_mode),   32'(mIr == 4'h0));
  endtask

  // One TCK cycle: drive inputs away from the edge, clock, update model, check.
  task automatic step(input logic t, input logic d);
    tms     = t;
    tdi     = d;
    bsr_tdo = 1'($urandom_range(0, 1));
    @(posedge clk);
    modelStep(t, d);
    #1;
    compareAll("cyc");
    if (counting) begin
      cntClkEn  += int'(bsr_clk_en);
      cntShift  += int'(bsr_shift);
      cntUpdate += int'(bsr_update);
    end
  endtask

  // Asynchronous reset pulse, checked before any clock edge can occur.
  task automatic doReset();
    #2 reset = 1'b1;
    #1;
    modelReset();
    compareAll("rst");
    checkVal("rst.tapState", 32'(tap_state),  32'd0);
    checkVal("rst.irOut",    32'(ir_out),     32'h2);
    checkVal("rst.mode",     32'(bsr_mode),   32'd0);
    checkVal("rst.strobes",  32'({bsr_clk_en, bsr_shift, bsr_update, tdo, tdo_en}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic toRti();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  // IR scan from RTI, ending back in RTI. Returns shifted-out bits and mode at UPD_IR.
  task automatic irScan(input logic [3:0] op, output logic [3:0] outBits, output logic modeAtUpd);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      outBits[i] = tdo;
      step(i == 3, op[i]);
    end
    step(1'b1, 1'b0);
    modeAtUpd = bsr_mode;
    step(1'b0, 1'b0);
    $display("ir scan op=%h tdo=%b ir_out=%h", op, outBits, ir_out);
  endtask

  // DR scan of n bits from RTI back to RTI, counting the boundary strobes on the way.
  task automatic drScan(input int n, input logic [31:0] pat, output logic [31:0] outBits);
    outBits   = '0;
    cntClkEn  = 0;
    cntShift  = 0;
    cntUpdate = 0;
    counting  = 1'b1;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      outBits[i] = tdo;
      step(i == n - 1, pat[i]);
    end
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    counting = 1'b0;
    $display("dr scan n=%0d tdo=%h clken=%0d shift=%0d update=%0d",
             n, outBits, cntClkEn, cntShift, cntUpdate);
  endtask

  initial begin
    logic [3:0]  irBits;
    logic [31:0] drBits;
    logic        modeUpd;
    int          n;

    reset   = 1'b1;
    tms     = 1'b0;
    tdi     = 1'b0;
    bsr_tdo = 1'b0;
    modelReset();
    #1;
    compareAll("init");
    @(negedge clk);
    reset = 1'b0;

    // Reset asserted in the middle of a DR shift.
    toRti();
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    checkVal("midShift.state", 32'(tap_state), 32'd4);
    doReset();
    $display("reset mid SH_DR -> tap_state=%0d ir_out=%h", tap_state, ir_out);

    // Five tms=1 edges reach TLR from every state.
    for (int s = 0; s < 16; s++) begin
      int budget;
      doReset();
      budget = 0;
      while (mState != s && budget < 2000) begin
        step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        budget++;
      end
      checkVal("sweep.reach", 32'(tap_state), 32'(s));
      for (int i = 0; i < 5; i++) step(1'b1, 1'($urandom_range(0, 1)));
      checkVal("sweep.tlr", 32'(tap_state), 32'd0);
      $display("sweep from state %0d -> tap_state=%0d", s, tap_state);
    end

    // IDCODE read straight after reset.
    doReset();
    step(1'b0, 1'b0);
    drScan(32, 32'h0, drBits);
    checkVal("idcode", drBits, IDCODE);

    // EXTEST: IR capture pattern, mode timing, boundary strobe counts.
    irScan(4'b0000, irBits, modeUpd);
    checkVal("extest.capture", 32'(irBits[1:0]), 32'b01);
    checkVal("extest.modeUpd", 32'(modeUpd), 32'd0);
    checkVal("extest.modeAfter", 32'(bsr_mode), 32'd1);
    n = $urandom_range(1, 16);
    drScan(n, $urandom, drBits);
    checkVal("extest.clken",  32'(cntClkEn),  32'(n + 1));
    checkVal("extest.shift",  32'(cntShift),  32'(n));
    checkVal("extest.update", 32'(cntUpdate), 32'd1);

    // BYPASS: one-cycle delay with a leading zero, no boundary activity.
    irScan(4'b1111, irBits, modeUpd);
    drScan(4, 32'b1101, drBits);
    checkVal("bypass.tdo",    drBits,           32'b1010);
    checkVal("bypass.strobe", 32'(cntClkEn + cntShift + cntUpdate), 32'd0);

    // SAMPLE with a pause in the middle of the IR shift, tdi toggling during pause.
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    checkVal("pause.state", 32'(tap_state), 32'd13);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    checkVal("pause.ir",   32'(ir_out),   32'h1);
    checkVal("pause.mode", 32'(bsr_mode), 32'd0);
    $display("paused ir scan -> ir_out=%h bsr_mode=%0d", ir_out, bsr_mode);

    // Randomized traffic, biased toward tms=0 so shifts last a while.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) doReset();
      step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
    end
    $display("random phase done, tap_state=%0d ir_out=%h", tap_state, ir_out);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
